// File: rtl/alu_issue_ctrl.sv
// Issue controller between decoder and ALU: scoreboards in-flight destinations,
// parks a hazarding op in a one-entry hold register and drives ALU/regfile controls.
package alu_issue_pkg;
  parameter int IMM_W = 32;

  typedef enum logic [1:0] {
    op_none = 2'd0,
    op_move = 2'd1,
    op_add  = 2'd2
  } alu_opcode_t;

  typedef enum logic {
    font_reg = 1'b0,
    font_imm = 1'b1
  } alu_s1_font_t;

  typedef logic [IMM_W-1:0] imm_t;
endpackage

module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dec_valid_i,
  output logic                        dec_ready_o,
  input  alu_opcode_t                 dec_opcode_i,
  input  alu_s1_font_t                dec_font_i,
  input  logic [$clog2(NUM_REGS)-1:0] dec_rs1_i,
  input  logic [$clog2(NUM_REGS)-1:0] dec_rs2_i,
  input  logic [$clog2(NUM_REGS)-1:0] dec_rd_i,
  input  logic                        dec_wb_wr_i,
  input  imm_t                        dec_imm_i,
  input  logic                        flush_i,
  input  logic                        wb_valid_i,
  input  logic [$clog2(NUM_REGS)-1:0] wb_reg_i,
  output alu_opcode_t                 alu_opcode_o,
  output alu_s1_font_t                alu_s1_font_o,
  output imm_t                        alu_src_3_o,
  output logic [$clog2(NUM_REGS)-1:0] rf_rs1_o,
  output logic [$clog2(NUM_REGS)-1:0] rf_rs2_o,
  output logic                        wb_wr_o,
  output logic [$clog2(NUM_REGS)-1:0] reg_dst_o,
  output logic [STALL_CNT_W-1:0]      stall_cnt_o
);
  localparam int REG_W = $clog2(NUM_REGS);

  typedef struct packed {
    alu_opcode_t      opcode;
    alu_s1_font_t     font;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             wb_wr;
    imm_t             imm;
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  op_t                    hold_q, dec_op, sel_op;
  logic [NUM_REGS-1:0]    busy_q, busy_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   sel_hazard, issue, capture, count_stall, sel_writes;

  // An op_none never reads or writes, so it can never be blocked.
  function automatic logic op_hazard(input op_t op, input logic [NUM_REGS-1:0] busy);
    logic rs1_used, rs2_used, writes;
    rs1_used  = (op.opcode != op_none) && (op.font == font_reg);
    rs2_used  = (op.opcode == op_add);
    writes    = op.wb_wr && (op.opcode != op_none);
    op_hazard = (rs1_used && busy[op.rs1]) || (rs2_used && busy[op.rs2]) ||
                (writes && busy[op.rd]);
  endfunction

  assign dec_op = '{opcode: dec_opcode_i, font: dec_font_i, rs1: dec_rs1_i,
                    rs2: dec_rs2_i, rd: dec_rd_i, wb_wr: dec_wb_wr_i, imm: dec_imm_i};

  always_comb begin
    sel_op     = (state_q == STALL) ? hold_q : dec_op;
    sel_hazard = op_hazard(sel_op, busy_q);
    sel_writes = sel_op.wb_wr && (sel_op.opcode != op_none);
  end

  always_comb begin
    state_d     = state_q;
    dec_ready_o = 1'b0;
    issue       = 1'b0;
    capture     = 1'b0;
    count_stall = 1'b0;
    if (rst || flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          dec_ready_o = 1'b1;
          if (dec_valid_i) begin
            if (!sel_hazard) begin
              issue = 1'b1;
            end else begin
              capture = 1'b1;
              state_d = STALL;
            end
          end
        end
        STALL: begin
          if (!sel_hazard) begin
            issue   = 1'b1;
            state_d = IDLE;
          end else begin
            count_stall = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Anything that is not a real issue presents an all-zero bubble to the ALU.
  always_comb begin
    alu_opcode_o  = op_none;
    alu_s1_font_o = font_reg;
    alu_src_3_o   = '0;
    rf_rs1_o      = '0;
    rf_rs2_o      = '0;
    wb_wr_o       = 1'b0;
    reg_dst_o     = '0;
    if (issue && (sel_op.opcode != op_none)) begin
      alu_opcode_o  = sel_op.opcode;
      alu_s1_font_o = sel_op.font;
      alu_src_3_o   = sel_op.imm;
      rf_rs1_o      = sel_op.rs1;
      rf_rs2_o      = sel_op.rs2;
      wb_wr_o       = sel_op.wb_wr;
      reg_dst_o     = sel_op.rd;
    end
  end

  // Set is applied after clear so a same-cycle set/clear of one register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid_i) busy_d[wb_reg_i] = 1'b0;
    if (issue && sel_writes) busy_d[sel_op.rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      if (flush_i) begin
        hold_q <= '0;
      end else if (capture) begin
        hold_q <= dec_op;
      end
      if (count_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, stall-counter saturation run,
// then random traffic compared against a queue-based issue model.
module tb_alu_issue_ctrl;
  import alu_issue_pkg::*;

  localparam int NUM_REGS    = 32;
  localparam int STALL_CNT_W = 16;
  localparam int REG_W       = 5;

  typedef struct {
    alu_opcode_t      opcode;
    alu_s1_font_t     font;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             wb_wr;
    imm_t             imm;
  } op_t;

  typedef struct {
    string            name;
    bit               valid;
    op_t              op;
    bit               flush;
    bit               wbv;
    logic [REG_W-1:0] wbr;
    bit               exp_ready;
    alu_opcode_t      exp_opcode;
    logic [REG_W-1:0] exp_rd;
    bit               exp_wb;
    logic [15:0]      exp_cnt;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   dec_valid_i;
  logic                   dec_ready_o;
  alu_opcode_t            dec_opcode_i;
  alu_s1_font_t           dec_font_i;
  logic [REG_W-1:0]       dec_rs1_i, dec_rs2_i, dec_rd_i;
  logic                   dec_wb_wr_i;
  imm_t                   dec_imm_i;
  logic                   flush_i;
  logic                   wb_valid_i;
  logic [REG_W-1:0]       wb_reg_i;
  alu_opcode_t            alu_opcode_o;
  alu_s1_font_t           alu_s1_font_o;
  imm_t                   alu_src_3_o;
  logic [REG_W-1:0]       rf_rs1_o, rf_rs2_o, reg_dst_o;
  logic                   wb_wr_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a register is "owed" while a writer has issued and not written back;
  // a decoded op waits in a queue of at most one entry until nothing it touches is owed.
  bit  owed[NUM_REGS];
  op_t waiting[$];
  int  stall_total;
  bit  m_ready, m_issue, m_capture, m_count;
  op_t m_out;

  alu_issue_ctrl #(.NUM_REGS(NUM_REGS), .STALL_CNT_W(STALL_CNT_W)) dut (
    .clk(clk), .rst(rst),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_opcode_i(dec_opcode_i), .dec_font_i(dec_font_i),
    .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i), .dec_rd_i(dec_rd_i),
    .dec_wb_wr_i(dec_wb_wr_i), .dec_imm_i(dec_imm_i),
    .flush_i(flush_i), .wb_valid_i(wb_valid_i), .wb_reg_i(wb_reg_i),
    .alu_opcode_o(alu_opcode_o), .alu_s1_font_o(alu_s1_font_o),
    .alu_src_3_o(alu_src_3_o), .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o),
    .wb_wr_o(wb_wr_o), .reg_dst_o(reg_dst_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic op_t mkop(alu_opcode_t opc, alu_s1_font_t font, int rs1, int rs2,
                               int rd, bit wb, int imm);
    op_t o;
    o.opcode = opc;
    o.font   = font;
    o.rs1    = REG_W'(rs1);
    o.rs2    = REG_W'(rs2);
    o.rd     = REG_W'(rd);
    o.wb_wr  = wb;
    o.imm    = imm_t'(imm);
    return o;
  endfunction

  function automatic vec_t row(string name, bit valid, op_t op, bit flush, bit wbv, int wbr,
                               bit er, alu_opcode_t eo, int erd, bit ewb, int ecnt);
    vec_t v;
    v.name = name; v.valid = valid; v.op = op; v.flush = flush; v.wbv = wbv;
    v.wbr = REG_W'(wbr); v.exp_ready = er; v.exp_opcode = eo; v.exp_rd = REG_W'(erd);
    v.exp_wb = ewb; v.exp_cnt = 16'(ecnt);
    return v;
  endfunction

  function automatic bit must_wait(op_t op);
    if (op.opcode == op_none) return 1'b0;
    if (op.font == font_reg && owed[op.rs1]) return 1'b1;
    if (op.opcode == op_add && owed[op.rs2]) return 1'b1;
    if (op.wb_wr && owed[op.rd]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_eval(input vec_t v);
    m_issue   = 1'b0;
    m_capture = 1'b0;
    m_count   = 1'b0;
    m_ready   = (waiting.size() == 0) && !v.flush;
    if (!v.flush) begin
      if (waiting.size() != 0) begin
        if (!must_wait(waiting[0])) begin m_issue = 1'b1; m_out = waiting[0]; end
        else m_count = 1'b1;
      end else if (v.valid) begin
        if (!must_wait(v.op)) begin m_issue = 1'b1; m_out = v.op; end
        else m_capture = 1'b1;
      end
    end
  endtask

  task automatic model_commit(input vec_t v);
    if (v.wbv) owed[v.wbr] = 1'b0;
    if (m_issue && m_out.opcode != op_none && m_out.wb_wr) owed[m_out.rd] = 1'b1;
    if (v.flush || m_issue) waiting.delete();
    if (m_capture) waiting.push_back(v.op);
    if (m_count && stall_total < 65535) stall_total++;
  endtask

  task automatic model_reset();
    foreach (owed[i]) owed[i] = 1'b0;
    waiting.delete();
    stall_total = 0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, let combinational outputs settle, compare, clock, advance the model.
  task automatic applyStimulus(input vec_t v, input bit use_table);
    logic [48:0] exp_bundle;
    dec_valid_i  = v.valid;
    dec_opcode_i = v.op.opcode;
    dec_font_i   = v.op.font;
    dec_rs1_i    = v.op.rs1;
    dec_rs2_i    = v.op.rs2;
    dec_rd_i     = v.op.rd;
    dec_wb_wr_i  = v.op.wb_wr;
    dec_imm_i    = v.op.imm;
    flush_i      = v.flush;
    wb_valid_i   = v.wbv;
    wb_reg_i     = v.wbr;
    #2;
    model_eval(v);
    if (m_issue && m_out.opcode != op_none)
      exp_bundle = {m_out.font, m_out.rs1, m_out.rs2, m_out.rd, m_out.wb_wr, m_out.imm};
    else
      exp_bundle = '0;
    checkOutput({v.name, "/ready"}, 64'(dec_ready_o), 64'(m_ready));
    checkOutput({v.name, "/opcode"}, 64'(alu_opcode_o),
                64'((m_issue && m_out.opcode != op_none) ? m_out.opcode : op_none));
    checkOutput({v.name, "/fields"},
                64'({alu_s1_font_o, rf_rs1_o, rf_rs2_o, reg_dst_o, wb_wr_o, alu_src_3_o}),
                64'(exp_bundle));
    checkOutput({v.name, "/stall_cnt"}, 64'(stall_cnt_o), 64'(stall_total));
    if (use_table) begin
      checkOutput({v.name, "/tbl_ready"}, 64'(dec_ready_o), 64'(v.exp_ready));
      checkOutput({v.name, "/tbl_opcode"}, 64'(alu_opcode_o), 64'(v.exp_opcode));
      checkOutput({v.name, "/tbl_rd_wb"}, 64'({reg_dst_o, wb_wr_o}), 64'({v.exp_rd, v.exp_wb}));
      checkOutput({v.name, "/tbl_cnt"}, 64'(stall_cnt_o), 64'(v.exp_cnt));
    end
    @(posedge clk);
    model_commit(v);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dec_valid_i = 1'b0; dec_opcode_i = op_none; dec_font_i = font_reg;
    dec_rs1_i = '0; dec_rs2_i = '0; dec_rd_i = '0; dec_wb_wr_i = 1'b0; dec_imm_i = '0;
    flush_i = 1'b0; wb_valid_i = 1'b0; wb_reg_i = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("reset/ready", 64'(dec_ready_o), 64'(0));
      checkOutput("reset/opcode", 64'(alu_opcode_o), 64'(op_none));
      checkOutput("reset/stall_cnt", 64'(stall_cnt_o), 64'(0));
    end
    rst = 1'b0;
    model_reset();
    #1;
    checkOutput("reset/ready_after", 64'(dec_ready_o), 64'(1));
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    op_t  nop;
    nop = mkop(op_none, font_reg, 0, 0, 0, 0, 0);

    tbl.push_back(row("b2b_move", 1, mkop(op_move, font_imm, 0, 0, 1, 1, 5), 0, 0, 0, 1, op_move, 1, 1, 0));
    tbl.push_back(row("b2b_add", 1, mkop(op_add, font_reg, 3, 4, 2, 1, 0), 0, 0, 0, 1, op_add, 2, 1, 0));
    tbl.push_back(row("wb_r1", 0, nop, 0, 1, 1, 1, op_none, 0, 0, 0));
    tbl.push_back(row("wb_r2", 0, nop, 0, 1, 2, 1, op_none, 0, 0, 0));
    tbl.push_back(row("raw_move", 1, mkop(op_move, font_imm, 0, 0, 1, 1, 7), 0, 0, 0, 1, op_move, 1, 1, 0));
    tbl.push_back(row("raw_add_held", 1, mkop(op_add, font_reg, 1, 2, 5, 1, 0), 0, 0, 0, 1, op_none, 0, 0, 0));
    tbl.push_back(row("raw_stall1", 0, nop, 0, 0, 0, 0, op_none, 0, 0, 0));
    tbl.push_back(row("raw_stall2_wb", 0, nop, 0, 1, 1, 0, op_none, 0, 0, 1));
    tbl.push_back(row("raw_issue", 0, nop, 0, 0, 0, 0, op_add, 5, 1, 2));
    tbl.push_back(row("raw_idle", 0, nop, 0, 0, 0, 1, op_none, 0, 0, 2));
    tbl.push_back(row("setclr_r6", 1, mkop(op_move, font_imm, 0, 0, 6, 1, 9), 0, 1, 6, 1, op_move, 6, 1, 2));
    tbl.push_back(row("r6_busy_held", 1, mkop(op_move, font_reg, 6, 0, 8, 1, 0), 0, 0, 0, 1, op_none, 0, 0, 2));
    tbl.push_back(row("r6_stall", 0, nop, 0, 0, 0, 0, op_none, 0, 0, 2));
    tbl.push_back(row("flush_held", 0, nop, 1, 0, 0, 0, op_none, 0, 0, 3));
    tbl.push_back(row("after_flush", 0, nop, 0, 0, 0, 1, op_none, 0, 0, 3));
    tbl.push_back(row("r5_busy_held", 1, mkop(op_add, font_reg, 5, 0, 9, 1, 0), 0, 0, 0, 1, op_none, 0, 0, 3));
    tbl.push_back(row("flush_no_cnt", 0, nop, 1, 0, 0, 0, op_none, 0, 0, 3));
    tbl.push_back(row("idle_again", 0, nop, 0, 0, 0, 1, op_none, 0, 0, 3));
    tbl.push_back(row("none_on_busy", 1, mkop(op_none, font_reg, 6, 6, 6, 1, 3), 0, 0, 0, 1, op_none, 0, 0, 3));
    tbl.push_back(row("none_no_stall", 0, nop, 0, 0, 0, 1, op_none, 0, 0, 3));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], 1'b1);

    // r6 is still owed, so this op sits in STALL until the counter pins at all-ones.
    applyStimulus(row("sat_capture", 1, mkop(op_move, font_reg, 6, 0, 10, 1, 0), 0, 0, 0,
                      1, op_none, 0, 0, 3), 1'b1);
    dec_valid_i = 1'b0;
    repeat (65531) @(posedge clk);
    #1;
    checkOutput("sat/before_top", 64'(stall_cnt_o), 64'(16'hFFFE));
    repeat (10) @(posedge clk);
    #1;
    checkOutput("sat/pinned", 64'(stall_cnt_o), 64'(16'hFFFF));
    checkOutput("sat/still_stalled", 64'(dec_ready_o), 64'(0));

    do_reset();
    for (int i = 0; i < 400; i++) begin
      v = row($sformatf("rand%0d", i), ($urandom_range(0, 9) < 7),
              mkop(alu_opcode_t'($urandom_range(0, 2)), alu_s1_font_t'($urandom_range(0, 1)),
                   $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 1), int'($urandom())),
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 4), $urandom_range(0, 7),
              0, op_none, 0, 0, 0);
      applyStimulus(v, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
